// File: rtl/gpdi_timing_ctrl.sv
// gpdi_timing_ctrl: video timing generator and pixel sequencer feeding the GPDI serializer.
// Defining GPDI_TEST_PATTERN_EN adds I_test_en and an internal 8-bar colour pattern.
module gpdi_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        I_pix_clk,
    input  logic        I_rst,
    input  logic [23:0] I_fifo_data,
    input  logic        I_fifo_empty,
    output logic        O_fifo_rd,
    input  logic        I_underrun_clr,
    output logic        O_underrun,
    output logic        O_frame_start,
    output logic        O_line_start,
    output logic        O_rgb_vs,
    output logic        O_rgb_hs,
    output logic        O_rgb_de,
    output logic [7:0]  O_rgb_r,
    output logic [7:0]  O_rgb_g,
`ifdef GPDI_TEST_PATTERN_EN
    output logic [7:0]  O_rgb_b,
    input  logic        I_test_en
`else
    output logic [7:0]  O_rgb_b
`endif
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_active;
    logic             w_hs_a;
    logic             w_vs_a;
    logic             w_test;
    logic             w_starve;
    logic             r_s1_active;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic             r_s1_starved;
    logic [23:0]      w_pix;

`ifdef GPDI_TEST_PATTERN_EN
    logic [2:0]       w_bar;
    logic [2:0]       r_s1_bar;
    logic             r_s1_test;
    assign w_test = I_test_en;
`else
    assign w_test = 1'b0;
`endif

    // Raster counters: h wraps at end of line and advances v.
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
        end else begin
            r_h <= r_h + CNT_W'(1);
        end
    end

    assign w_active  = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs_a    = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
    assign w_vs_a    = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);
    assign w_starve  = w_active && I_fifo_empty && !w_test;
    assign O_fifo_rd = w_active && !I_fifo_empty && !w_test && !I_rst;

    // Sticky underrun; a new starvation wins over a clear in the same cycle.
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            O_underrun <= 1'b0;
        end else if (w_starve) begin
            O_underrun <= 1'b1;
        end else if (I_underrun_clr) begin
            O_underrun <= 1'b0;
        end
    end

    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            O_frame_start <= 1'b0;
            O_line_start  <= 1'b0;
        end else begin
            O_frame_start <= (r_h == '0) && (r_v == '0);
            O_line_start  <= (r_h == '0) && (r_v < V_ACT);
        end
    end

    // Stage 1: hold timing flags while the FIFO returns the pixel.
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            r_s1_active  <= 1'b0;
            r_s1_hs      <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s1_starved <= 1'b0;
        end else begin
            r_s1_active  <= w_active;
            r_s1_hs      <= w_hs_a;
            r_s1_vs      <= w_vs_a;
            r_s1_starved <= w_starve;
        end
    end

`ifdef GPDI_TEST_PATTERN_EN
    // Bar index = floor(h*8/H_ACTIVE) via constant thresholds, registered into stage 1.
    always_comb begin
        w_bar = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if ({3'b000, r_h, 3'b000} >= 18'(k * H_ACTIVE)) begin
                w_bar = 3'(k);
            end
        end
    end

    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            r_s1_bar  <= 3'd0;
            r_s1_test <= 1'b0;
        end else begin
            r_s1_bar  <= w_bar;
            r_s1_test <= I_test_en;
        end
    end
`endif

    always_comb begin
        w_pix = 24'h000000;
        if (r_s1_active && !r_s1_starved) begin
            w_pix = I_fifo_data;
        end
`ifdef GPDI_TEST_PATTERN_EN
        if (r_s1_active && r_s1_test) begin
            w_pix = {{8{~r_s1_bar[1]}}, {8{~r_s1_bar[2]}}, {8{~r_s1_bar[0]}}};
        end
`endif
    end

    // Stage 2: registered outputs to the serializer.
    always_ff @(posedge I_pix_clk) begin
        if (I_rst) begin
            O_rgb_de <= 1'b0;
            O_rgb_hs <= ~HS_POL;
            O_rgb_vs <= ~VS_POL;
            O_rgb_r  <= 8'h00;
            O_rgb_g  <= 8'h00;
            O_rgb_b  <= 8'h00;
        end else begin
            O_rgb_de <= r_s1_active;
            O_rgb_hs <= r_s1_hs ? HS_POL : ~HS_POL;
            O_rgb_vs <= r_s1_vs ? VS_POL : ~VS_POL;
            O_rgb_r  <= w_pix[23:16];
            O_rgb_g  <= w_pix[15:8];
            O_rgb_b  <= w_pix[7:0];
        end
    end

endmodule

// File: tb/tb_gpdi_timing_ctrl.sv
// Scoreboard bench for gpdi_timing_ctrl on an 8x6 raster (4x3 active).
// With GPDI_TEST_PATTERN_EN defined, a second instance checks the colour bars.
module tb_gpdi_timing_ctrl;

    logic        I_pix_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic [23:0] I_fifo_data = 24'hA5A5A5;
    logic        I_fifo_empty = 1'b0;
    logic        I_underrun_clr = 1'b0;
    logic        O_fifo_rd, O_underrun, O_frame_start, O_line_start;
    logic        O_rgb_vs, O_rgb_hs, O_rgb_de;
    logic [7:0]  O_rgb_r, O_rgb_g, O_rgb_b;

    gpdi_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut (
        .I_pix_clk(I_pix_clk), .I_rst(I_rst),
        .I_fifo_data(I_fifo_data), .I_fifo_empty(I_fifo_empty), .O_fifo_rd(O_fifo_rd),
        .I_underrun_clr(I_underrun_clr), .O_underrun(O_underrun),
        .O_frame_start(O_frame_start), .O_line_start(O_line_start),
        .O_rgb_vs(O_rgb_vs), .O_rgb_hs(O_rgb_hs), .O_rgb_de(O_rgb_de),
        .O_rgb_r(O_rgb_r), .O_rgb_g(O_rgb_g),
`ifdef GPDI_TEST_PATTERN_EN
        .O_rgb_b(O_rgb_b), .I_test_en(1'b0)
`else
        .O_rgb_b(O_rgb_b)
`endif
    );

    always #5 I_pix_clk = ~I_pix_clk;

    typedef struct packed { logic de; logic hs; logic vs; } sync_t;
    typedef struct packed { logic fs; logic ls; logic uf; } mark_t;

    sync_t       sync_q[$];
    mark_t       mk_q[$];
    logic [23:0] px_q[$];
    logic [23:0] fifo_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;
    int rst_cnt = 3;
    int rd_cnt = 0;
    bit phase2 = 1'b0;
    bit done = 1'b0;
    bit rd_prev = 1'b0;
    bit exp_rd = 1'b0;
    bit exp_uf = 1'b0;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d: got %06h, want %06h", name, t, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s t=%0d", name, t);
    endtask

    // Driver: upstream FIFO model, schedule of starve/clear/reset events, expectation pushes.
    always @(negedge I_pix_clk) begin : p_drv
        int  h, v;
        bit  act, forced;
        if (rd_prev) begin
            if (fifo_q.size() > 0) I_fifo_data = fifo_q.pop_front();
            else                   I_fifo_data = 24'hEEEEEE;
        end else begin
            I_fifo_data = 24'hA5A5A5;
        end
        if (!phase2 && !I_rst && (t + 1 == 210)) begin
            rst_cnt = 1;
            phase2  = 1'b1;
        end
        if (rst_cnt > 0) begin
            rst_cnt--;
            I_rst = 1'b1;
            I_underrun_clr = 1'b0;
            I_fifo_empty = (fifo_q.size() == 0);
            sync_q.delete();
            mk_q.delete();
            px_q.delete();
            exp_uf = 1'b0;
            exp_rd = 1'b0;
        end else begin
            if (I_rst) begin
                I_rst = 1'b0;
                t = 0;
                sync_q.push_back('{1'b0, 1'b1, 1'b1});
            end else begin
                t++;
            end
            if (!phase2 && t == 96) chk("reads_2frames", 24'(rd_cnt), 24'd24);
            if (phase2 && t == 60) done = 1'b1;
            h = t % 8;
            v = (t / 8) % 6;
            if (h == 0 && v == 0 && fifo_q.size() < 12) begin
                for (int i = 1; i <= 12; i++) fifo_q.push_back(24'(i));
            end
            act    = (h < 4) && (v < 3);
            forced = !phase2 && (t == 106 || t == 144);
            I_fifo_empty   = forced || (fifo_q.size() == 0);
            I_underrun_clr = !phase2 && (t == 120 || t == 144);
            exp_rd = act && !I_fifo_empty;
            if (act) begin
                if (I_fifo_empty) px_q.push_back(24'h000000);
                else              px_q.push_back(fifo_q[0]);
            end
            sync_q.push_back('{act, !(h == 5 || h == 6), !(v == 4)});
            if (act && I_fifo_empty) exp_uf = 1'b1;
            else if (I_underrun_clr) exp_uf = 1'b0;
            mk_q.push_back('{(h == 0 && v == 0), (h == 0 && v < 3), exp_uf});
        end
        #1;
        chk("fifo_rd", 24'(O_fifo_rd), 24'(exp_rd));
        rd_prev = O_fifo_rd;
        if (O_fifo_rd && !I_rst && !phase2 && t < 96) rd_cnt++;
    end

    // Monitor: compare registered outputs just after each active edge.
    always @(posedge I_pix_clk) begin : p_mon
        logic  rs;
        sync_t s;
        mark_t m;
        rs = I_rst;
        #1;
        if (rs) begin
            chk("rst_de", 24'(O_rgb_de), 24'd0);
            chk("rst_hs", 24'(O_rgb_hs), 24'd1);
            chk("rst_vs", 24'(O_rgb_vs), 24'd1);
            chk("rst_rgb", {O_rgb_r, O_rgb_g, O_rgb_b}, 24'h000000);
            chk("rst_fs", 24'(O_frame_start), 24'd0);
            chk("rst_ls", 24'(O_line_start), 24'd0);
            chk("rst_uf", 24'(O_underrun), 24'd0);
        end else begin
            if (sync_q.size() == 0) begin
                fail_now("sync_q_empty");
            end else begin
                s = sync_q.pop_front();
                chk("de", 24'(O_rgb_de), 24'(s.de));
                chk("hs", 24'(O_rgb_hs), 24'(s.hs));
                chk("vs", 24'(O_rgb_vs), 24'(s.vs));
            end
            if (O_rgb_de) begin
                if (px_q.size() == 0) fail_now("px_q_empty");
                else chk("rgb", {O_rgb_r, O_rgb_g, O_rgb_b}, px_q.pop_front());
            end else begin
                chk("blank_rgb", {O_rgb_r, O_rgb_g, O_rgb_b}, 24'h000000);
            end
            if (mk_q.size() == 0) begin
                fail_now("mk_q_empty");
            end else begin
                m = mk_q.pop_front();
                chk("frame_start", 24'(O_frame_start), 24'(m.fs));
                chk("line_start", 24'(O_line_start), 24'(m.ls));
                chk("underrun", 24'(O_underrun), 24'(m.uf));
            end
        end
    end

`ifdef GPDI_TEST_PATTERN_EN
    logic        p_rd, p_uf, p_fs, p_ls, p_vs, p_hs, p_de;
    logic [7:0]  p_r, p_g, p_b;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int          p_idx = 0;

    gpdi_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_pat (
        .I_pix_clk(I_pix_clk), .I_rst(I_rst),
        .I_fifo_data(24'h123456), .I_fifo_empty(1'b0), .O_fifo_rd(p_rd),
        .I_underrun_clr(1'b0), .O_underrun(p_uf),
        .O_frame_start(p_fs), .O_line_start(p_ls),
        .O_rgb_vs(p_vs), .O_rgb_hs(p_hs), .O_rgb_de(p_de),
        .O_rgb_r(p_r), .O_rgb_g(p_g), .O_rgb_b(p_b), .I_test_en(1'b1)
    );

    always @(posedge I_pix_clk) begin : p_pat
        logic rs;
        rs = I_rst;
        #1;
        chk("pat_fifo_rd", 24'(p_rd), 24'd0);
        chk("pat_underrun", 24'(p_uf), 24'd0);
        if (rs) begin
            p_idx = 0;
        end else if (p_de) begin
            chk("pat_rgb", {p_r, p_g, p_b}, bars[p_idx]);
            p_idx = (p_idx + 1) % 8;
        end
    end
`endif

    initial begin
        for (int i = 1; i <= 12; i++) fifo_q.push_back(24'(i));
        for (int c = 0; c < 1000; c++) begin
            @(posedge I_pix_clk);
            if (done) break;
        end
        if (!done) fail_now("timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
